// File: rtl/pe_array_pkg.sv
// Shared state encoding and phase-length helpers for the PE array job sequencer.
package pe_array_pkg;

    localparam int unsigned DEFAULT_SYSTOLIC_SIZE = 16;
    localparam int unsigned DEFAULT_DATA_WIDTH    = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        FLUSH = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } seq_state_e;

    // Long enough for the last skewed operand to cross the full diagonal and land in the far-corner accumulator.
    function automatic int unsigned flush_cycles(input int unsigned size, input int unsigned pe_lat);
        return 2 * size + pe_lat - 1;
    endfunction

    function automatic int unsigned drain_cycles(input int unsigned size, input int unsigned out_lat);
        return size + out_lat;
    endfunction

endpackage

// File: rtl/pe_skew_buf.sv
// Triangular operand skew: lane i is delayed by i register stages, each stage carrying
// a valid bit so that empty slots present zero to the array edge.
module pe_skew_buf #(
    parameter int unsigned SIZE = 16,
    parameter int unsigned DW   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 vld_i,
    input  logic [SIZE*DW-1:0]   data_i,
    output logic [SIZE*DW-1:0]   data_o
);

    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        if (i == 0) begin : g_direct
            assign data_o[DW-1:0] = vld_i ? data_i[DW-1:0] : '0;
        end else begin : g_delay
            logic [DW-1:0] d_q [i];
            logic [i-1:0]  v_q;

            always_ff @(posedge clk or negedge rst_n) begin
                // NOTE: the stage array is reset on purpose; a stale valid bit after an abort would leak old operands into the next job.
                if (!rst_n) begin
                    d_q <= '{default: '0};
                    v_q <= '0;
                end else begin
                    // NOTE: non-blocking updates let every stage sample its predecessor's pre-edge value, so the chain shifts by exactly one.
                    d_q[0] <= data_i[i*DW +: DW];
                    v_q[0] <= vld_i;
                    for (int s = 1; s < i; s++) begin
                        d_q[s] <= d_q[s-1];
                        v_q[s] <= v_q[s-1];
                    end
                end
            end

            assign data_o[i*DW +: DW] = v_q[i-1] ? d_q[i-1] : '0;
        end
    end

endmodule

// File: rtl/pe_array_seq_ctrl.sv
// Job sequencer for the output-stationary systolic array: clear, skewed feed, flush, drain.
// Define PE_ARRAY_SEQ_PERF_EN to add saturating busy-cycle and completed-job counters.
module pe_array_seq_ctrl
    import pe_array_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int unsigned SYSTOLIC_SIZE = DEFAULT_SYSTOLIC_SIZE,
    parameter int unsigned K_WIDTH       = 16,
    parameter int unsigned PE_LAT        = 1,
    parameter int unsigned OUT_LAT       = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic [K_WIDTH-1:0]                  k_len,
    output logic                                busy,
    output logic                                done,
    output logic                                rd_en,
    output logic [K_WIDTH-1:0]                  rd_addr,
    input  logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0] wgt_rd_data,
    input  logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0] ifm_rd_data,
    output logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0] wgt_in,
    output logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0] ifm_in,
    output logic                                reset_pe,
    output logic                                write_out_en,
    output logic                                ofm_valid,
    output logic [$clog2(SYSTOLIC_SIZE)-1:0]    ofm_col
`ifdef PE_ARRAY_SEQ_PERF_EN
    ,
    output logic [31:0]                         perf_busy_cycles,
    output logic [15:0]                         perf_jobs
`endif
);

    localparam int unsigned FLUSH_N = flush_cycles(SYSTOLIC_SIZE, PE_LAT);
    localparam int unsigned DRAIN_N = drain_cycles(SYSTOLIC_SIZE, OUT_LAT);
    localparam int unsigned PH_W    = $clog2(FLUSH_N > DRAIN_N ? FLUSH_N : DRAIN_N);
    localparam int unsigned COL_W   = $clog2(SYSTOLIC_SIZE);

    seq_state_e         state_q, state_d;
    logic [K_WIDTH-1:0] k_q, k_d;
    logic [K_WIDTH-1:0] addr_q, addr_d;
    logic [PH_W-1:0]    ph_q, ph_d;
    logic               vld_q;
    logic [OUT_LAT-1:0] wo_pipe_q;
    logic [COL_W-1:0]   col_q;

    always_comb begin
        // NOTE: every next-state and output is defaulted first, so no branch leaves a value unassigned and no latch is inferred.
        state_d      = state_q;
        k_d          = k_q;
        addr_d       = addr_q;
        ph_d         = ph_q;
        busy         = (state_q != IDLE);
        done         = 1'b0;
        reset_pe     = 1'b0;
        rd_en        = 1'b0;
        write_out_en = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    k_d     = k_len;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                reset_pe = 1'b1;
                state_d  = (k_q == '0) ? FLUSH : FEED;
            end
            FEED: begin
                rd_en = 1'b1;
                // Compare against K-1 rather than K so the full-range depth never needs a wider counter.
                if (addr_q == k_q - K_WIDTH'(1)) begin
                    addr_d  = '0;
                    state_d = FLUSH;
                end else begin
                    addr_d = addr_q + K_WIDTH'(1);
                end
            end
            FLUSH: begin
                if (ph_q == PH_W'(FLUSH_N - 1)) begin
                    ph_d    = '0;
                    state_d = DRAIN;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            DRAIN: begin
                write_out_en = (ph_q < PH_W'(SYSTOLIC_SIZE));
                if (ph_q == PH_W'(DRAIN_N - 1)) begin
                    ph_d    = '0;
                    state_d = DONE;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            k_q       <= '0;
            addr_q    <= '0;
            ph_q      <= '0;
            vld_q     <= 1'b0;
            wo_pipe_q <= '0;
            col_q     <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            addr_q    <= addr_d;
            ph_q      <= ph_d;
            vld_q     <= rd_en;
            wo_pipe_q <= OUT_LAT'({wo_pipe_q, write_out_en});
            if (ofm_valid) begin
                col_q <= (col_q == COL_W'(SYSTOLIC_SIZE - 1)) ? '0 : col_q + COL_W'(1);
            end
        end
    end

    assign rd_addr   = addr_q;
    assign ofm_valid = wo_pipe_q[OUT_LAT-1];
    assign ofm_col   = col_q;

    // Buffer data returns one cycle after rd_en, so the registered strobe qualifies it.
    pe_skew_buf #(
        .SIZE (SYSTOLIC_SIZE),
        .DW   (DATA_WIDTH)
    ) u_ifm_skew (
        .clk    (clk),
        .rst_n  (rst_n),
        .vld_i  (vld_q),
        .data_i (ifm_rd_data),
        .data_o (ifm_in)
    );

    pe_skew_buf #(
        .SIZE (SYSTOLIC_SIZE),
        .DW   (DATA_WIDTH)
    ) u_wgt_skew (
        .clk    (clk),
        .rst_n  (rst_n),
        .vld_i  (vld_q),
        .data_i (wgt_rd_data),
        .data_o (wgt_in)
    );

`ifdef PE_ARRAY_SEQ_PERF_EN
    logic [31:0] perf_busy_q;
    logic [15:0] perf_jobs_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_busy_q <= '0;
            perf_jobs_q <= '0;
        end else begin
            if (busy && (perf_busy_q != '1)) perf_busy_q <= perf_busy_q + 32'd1;
            if (done && (perf_jobs_q != '1)) perf_jobs_q <= perf_jobs_q + 16'd1;
        end
    end

    assign perf_busy_cycles = perf_busy_q;
    assign perf_jobs        = perf_jobs_q;
`endif

endmodule

// File: tb/tb_pe_array_seq_ctrl.sv
// Directed bench for pe_array_seq_ctrl: cycle-exact timeline and skew checks, plus a
// behavioural PE array whose accumulators are scored against a golden matrix product.
module tb_pe_array_seq_ctrl;

    localparam int N     = 16;
    localparam int DW    = 16;
    localparam int KW    = 16;
    localparam int VW    = N * DW;
    localparam int FRAC  = 8;
    localparam int FLUSH = 32;   // 2*16 + 1 - 1
    localparam int DRAIN = 17;   // 16 + 1

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [KW-1:0] k_len = '0;
    logic          busy, done, rd_en, reset_pe, write_out_en, ofm_valid;
    logic [KW-1:0] rd_addr;
    logic [VW-1:0] wgt_rd_data = '0;
    logic [VW-1:0] ifm_rd_data = '0;
    logic [VW-1:0] wgt_in, ifm_in;
    logic [3:0]    ofm_col;
`ifdef PE_ARRAY_SEQ_PERF_EN
    logic [31:0]   perf_busy_cycles;
    logic [15:0]   perf_jobs;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [VW-1:0] wgt_mem [256];
    logic [VW-1:0] ifm_mem [256];
    logic [VW-1:0] exp_q [$];

    always #5 clk = ~clk;

    pe_array_seq_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .k_len        (k_len),
        .busy         (busy),
        .done         (done),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .wgt_rd_data  (wgt_rd_data),
        .ifm_rd_data  (ifm_rd_data),
        .wgt_in       (wgt_in),
        .ifm_in       (ifm_in),
        .reset_pe     (reset_pe),
        .write_out_en (write_out_en),
        .ofm_valid    (ofm_valid),
        .ofm_col      (ofm_col)
`ifdef PE_ARRAY_SEQ_PERF_EN
        ,
        .perf_busy_cycles (perf_busy_cycles),
        .perf_jobs        (perf_jobs)
`endif
    );

    // Q8.8 multiply, arithmetic-shift truncation, result taken modulo 2^DW.
    function automatic logic [DW-1:0] qmul(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic signed [2*DW-1:0] p;
        p = $signed(a) * $signed(b);
        return p[FRAC +: DW];
    endfunction

    // Behavioural output-stationary array: ifm moves right, weights move down.
    logic [DW-1:0] acc [N][N];
    logic [DW-1:0] a_q [N][N];
    logic [DW-1:0] b_q [N][N];
    logic [DW-1:0] ma, mb;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    acc[i][j] <= '0;
                    a_q[i][j] <= '0;
                    b_q[i][j] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    ma = (j == 0) ? ifm_in[i*DW +: DW] : a_q[i][(j == 0) ? 0 : j-1];
                    mb = (i == 0) ? wgt_in[j*DW +: DW] : b_q[(i == 0) ? 0 : i-1][j];
                    a_q[i][j] <= ma;
                    b_q[i][j] <= mb;
                    acc[i][j] <= reset_pe ? '0 : acc[i][j] + qmul(ma, mb);
                end
            end
        end
    end

    function automatic logic [VW-1:0] model_col(input int c);
        logic [VW-1:0] v;
        v = '0;
        for (int r = 0; r < N; r++) v[r*DW +: DW] = acc[r][c];
        return v;
    endfunction

    // Expected array-edge vector t cycles after accept: element e of lane l arrives at t = 3 + e + l.
    function automatic logic [VW-1:0] exp_skew(input bit is_ifm, input int t, input int k);
        logic [VW-1:0] v;
        logic [VW-1:0] word;
        int e;
        v = '0;
        for (int l = 0; l < N; l++) begin
            e = t - 3 - l;
            if (e >= 0 && e < k) begin
                word = is_ifm ? ifm_mem[e] : wgt_mem[e];
                v[l*DW +: DW] = word[l*DW +: DW];
            end
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Advance one cycle; the buffer answers the previous cycle's read, garbage otherwise.
    task automatic tick();
        logic          req;
        logic [KW-1:0] a;
        req = rd_en;
        a   = rd_addr;
        @(posedge clk);
        #1;
        if (req) begin
            wgt_rd_data = wgt_mem[a[7:0]];
            ifm_rd_data = ifm_mem[a[7:0]];
        end else begin
            wgt_rd_data = {8{$urandom}};
            ifm_rd_data = {8{$urandom}};
        end
    endtask

    task automatic push_golden(input int k);
        logic [VW-1:0] col;
        logic [VW-1:0] iw;
        logic [VW-1:0] ww;
        logic [DW-1:0] s;
        for (int c = 0; c < N; c++) begin
            col = '0;
            for (int r = 0; r < N; r++) begin
                s = '0;
                for (int e = 0; e < k; e++) begin
                    iw = ifm_mem[e];
                    ww = wgt_mem[e];
                    s  = s + qmul(iw[r*DW +: DW], ww[c*DW +: DW]);
                end
                col[r*DW +: DW] = s;
            end
            exp_q.push_back(col);
        end
    endtask

    task automatic fill_random();
        for (int e = 0; e < 256; e++) begin
            wgt_mem[e] = {8{$urandom}};
            ifm_mem[e] = {8{$urandom}};
        end
    endtask

    // Runs one job from its accept cycle (t=0) through DONE, checking every output each cycle.
    task automatic run_job(input int k, input bit hold);
        int done_t, wo_first, ov_first, ov_last;
        done_t   = 1 + k + FLUSH + DRAIN + 1;
        wo_first = 1 + k + FLUSH + 1;
        ov_first = wo_first + 1;
        ov_last  = wo_first + N;
        push_golden(k);
        for (int t = 0; t <= done_t; t++) begin
            tick();
            if (t == 0) begin
                start = 1'b1;
                k_len = KW'(k);
            end else if (t == 1) begin
                k_len = KW'($urandom);
                if (!hold) start = 1'b0;
            end
            @(negedge clk);
            check("busy",         VW'(busy),         VW'(t >= 1));
            check("done",         VW'(done),         VW'(t == done_t));
            check("reset_pe",     VW'(reset_pe),     VW'(t == 1));
            check("rd_en",        VW'(rd_en),        VW'(t >= 2 && t <= k + 1));
            check("rd_addr",      VW'(rd_addr),      (t >= 2 && t <= k + 1) ? VW'(t - 2) : '0);
            check("write_out_en", VW'(write_out_en), VW'(t >= wo_first && t < wo_first + N));
            check("ofm_valid",    VW'(ofm_valid),    VW'(t >= ov_first && t <= ov_last));
            check("ofm_col",      VW'(ofm_col),      (t >= ov_first && t <= ov_last) ? VW'(t - ov_first) : '0);
            check("ifm_in",       ifm_in,            exp_skew(1'b1, t, k));
            check("wgt_in",       wgt_in,            exp_skew(1'b0, t, k));
            if (t >= ov_first && t <= ov_last) begin
                check("sb_pending", VW'(exp_q.size() != 0), VW'(1));
                if (exp_q.size() != 0) check("ofm_data", model_col(t - ov_first), exp_q.pop_front());
            end
        end
        check("sb_empty", VW'(exp_q.size()), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_seen;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy",     VW'(busy),         '0);
        check("rst_done",     VW'(done),         '0);
        check("rst_rd_en",    VW'(rd_en),        '0);
        check("rst_rd_addr",  VW'(rd_addr),      '0);
        check("rst_reset_pe", VW'(reset_pe),     '0);
        check("rst_wo_en",    VW'(write_out_en), '0);
        check("rst_ofm_vld",  VW'(ofm_valid),    '0);
        check("rst_ofm_col",  VW'(ofm_col),      '0);
        check("rst_ifm_in",   ifm_in,            '0);
        check("rst_wgt_in",   wgt_in,            '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // K=4, identity weights (1.0 in Q8.8), ifm lane i = i+1
        for (int e = 0; e < 256; e++) begin
            wgt_mem[e] = '0;
            ifm_mem[e] = '0;
            for (int l = 0; l < N; l++) begin
                ifm_mem[e][l*DW +: DW] = DW'(l + 1);
                if (l == e) wgt_mem[e][l*DW +: DW] = 16'h0100;
            end
        end
        run_job(4, 1'b0);

        // K=1 skew: every weight lane 1.0, so PE(i,j) = i+1
        for (int l = 0; l < N; l++) wgt_mem[0][l*DW +: DW] = 16'h0100;
        run_job(1, 1'b0);

        // K=0: FEED skipped, all results zero
        repeat (3) begin
            tick();
            @(negedge clk);
        end
        run_job(0, 1'b0);

        // start held high: second job accepted the cycle after DONE, accumulators cleared between
        fill_random();
        run_job(3, 1'b1);
        fill_random();
        run_job(5, 1'b0);

        // Reset during FLUSH aborts the job with no done pulse
        fill_random();
        tick();
        start = 1'b1;
        k_len = 16'd4;
        @(negedge clk);
        for (int t = 1; t <= 20; t++) begin
            tick();
            start = 1'b0;
            @(negedge clk);
        end
        check("pre_abort_busy", VW'(busy), VW'(1));
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy",     VW'(busy),         '0);
        check("abort_wo_en",    VW'(write_out_en), '0);
        check("abort_ofm_vld",  VW'(ofm_valid),    '0);
        check("abort_done",     VW'(done),         '0);
        check("abort_ifm_in",   ifm_in,            '0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        done_seen = 0;
        for (int t = 0; t < 60; t++) begin
            tick();
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        check("no_done_after_abort", VW'(done_seen), '0);
        fill_random();
        run_job(4, 1'b0);

        // Boundary: K=255 random data, rd_addr climbs to 254 without wrapping
        fill_random();
        run_job(255, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_array_seq_ctrl.md
Name: pe_array_seq_ctrl

Overview:
- Job-level sequencer for the 16x16 output-stationary systolic PE array.
- Per job it does four things in order:
  - clears the accumulators;
  - streams K operand vectors from the weight/ifm buffers, applying the diagonal skew;
  - flushes the array;
  - drains the 16 result columns through the mac chain using write_out_en.
- Sits between the tile scheduler (start/done) and the array plus its operand buffers.

Parameters:
- DATA_WIDTH, 16, operand/result width.
- SYSTOLIC_SIZE, 16, array rows/cols.
- K_WIDTH, 16, width of the accumulation-depth field.
- PE_LAT, 1, PE multiply-accumulate register latency.
- OUT_LAT, 1, cycles from write_out_en to valid ofm_out.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  job request; accepted when start=1 and busy=0.
- k_len  in  K_WIDTH  accumulation depth; sampled at accept.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse at job end.
- rd_en  out  1  operand buffer read strobe; data is returned 1 cycle later.
- rd_addr  out  K_WIDTH  operand index 0..K-1.
- wgt_rd_data  in  SYSTOLIC_SIZE*DATA_WIDTH  weight vector from buffer.
- ifm_rd_data  in  SYSTOLIC_SIZE*DATA_WIDTH  ifm vector from buffer.
- wgt_in  out  SYSTOLIC_SIZE*DATA_WIDTH  skewed weights to array top.
- ifm_in  out  SYSTOLIC_SIZE*DATA_WIDTH  skewed ifm to array left.
- reset_pe  out  1  accumulator clear.
- write_out_en  out  1  result shift enable.
- ofm_valid  out  1  ofm_out is valid this cycle.
- ofm_col  out  $clog2(SYSTOLIC_SIZE)  index of the column currently on ofm_out.

Behaviour:
- Reset:
  - Async assert forces IDLE.
  - All outputs are 0, all counters are 0, all skew registers are 0.
  - Reset mid-job aborts the job with no done pulse.
- States and transitions:
  - IDLE to CLEAR on start (k_len latched).
  - CLEAR: 1 cycle, reset_pe=1.
  - FEED: K cycles, rd_en=1, rd_addr counts 0..K-1. If K=0, FEED is skipped.
  - FLUSH: FLUSH_CYCLES = 2*SYSTOLIC_SIZE+PE_LAT-1 cycles (32 at defaults), with zero operands.
  - DRAIN: SYSTOLIC_SIZE+OUT_LAT cycles. write_out_en=1 for the first SYSTOLIC_SIZE cycles only.
  - DONE: 1 cycle, done=1, then IDLE.
- busy is 1 from the cycle after accept through DONE inclusive. start while busy is ignored (not queued).
- Skew:
  - rd_en delayed by 1 cycle gives the data-valid flag.
  - Lane i of both ifm and wgt passes through i registers, each carrying data plus a valid bit.
  - A lane outputs 0 when its valid bit is 0.
  - Lane 0 therefore carries buffer data with 0 added delay after the read latency.
  - Element k reaches PE(i,j) at T0+1+k+i+j, where T0 is the first FEED cycle.
- Output:
  - ofm_valid is write_out_en delayed by OUT_LAT cycles.
  - ofm_col increments 0..SYSTOLIC_SIZE-1 on each valid cycle and returns to 0 after the last.
- Timing at defaults, K=4, start accepted in cycle 0:
  - reset_pe in cycle 1.
  - rd_en in cycles 2-5.
  - write_out_en in cycles 38-53.
  - ofm_valid in cycles 39-54.
  - done in cycle 55; the next start can be accepted in cycle 56.
- K=2^K_WIDTH-1 is legal; counters must not wrap early.

Optional Feature:
- PE_ARRAY_SEQ_PERF_EN defined:
  - Adds output perf_busy_cycles (32 bits), which increments every cycle busy=1.
  - Adds output perf_jobs (16 bits), which increments on done; both saturate.
  - Both clear on reset only.
- Not defined: these ports and their logic are absent.

Decomposition:
- Shared package pe_array_pkg holds:
  - the state enum (IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE);
  - FLUSH_CYCLES and DRAIN_CYCLES constant functions;
  - the default SYSTOLIC_SIZE and DATA_WIDTH.
- One sub-module, pe_skew_buf, is instantiated twice (ifm, wgt). It implements the triangular delay with per-lane valid-gating.

Test Plan:
- Reset and idle: reset, K=4 with identity weights and ifm values 1..16 -> timeline exactly as in Behaviour; all 16 columns match the golden model.
- Skew: K=1, ifm lane i = i+1, wgt lane j = 1 -> ifm_in lane 15 is nonzero only in cycle T0+16; PE(i,j) result = i+1.
- K=0 -> reset_pe, then FLUSH, then DRAIN; all ofm values 0; done in cycle 51.
- start held high continuously -> back-to-back jobs, each start accepted in the cycle after DONE; second job results unaffected by the first (clear verified).
- Reset mid-job: assert rst_n=0 during FLUSH -> busy, write_out_en and ofm_valid drop immediately; no done; the next job is correct.
- Boundary K=255 with random data -> rd_addr reaches 254 with no wrap; results match the golden model modulo DATA_WIDTH with Q-format truncation.
